uart_tx: RTL and testbench

- Serial transmitter for the UART link; the peer of the receive path and its parity checker.
- Accepts one parallel byte per handshake and serialises it LSB first.
- Frame: start bit, 8 data bits, optional parity bit, one stop bit.
- Runs on the bit-rate clock: one CLK cycle equals one bit time on TX_OUT.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_if.sv | 14 +
 rtl/uart_tx_parity_gen.sv | 13 +
 rtl/uart_tx.sv | 112 +++++++++++
 tb/tb_uart_tx.sv | 130 +++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: encodings and line levels shared by the UART transmit and receive paths.
package uart_pkg;

  // FSM state encoding
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = IDLE,
    S_START  = START,
    S_DATA   = DATA,
    S_PARITY = PARITY,
    S_STOP   = STOP
  } tx_state_t;

  // Parity type select
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Serial line levels
  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: parallel request side plus serial line / busy status of the transmitter.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  busy;

  modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYP, input TX_OUT, busy);
  modport slave  (input P_DATA, Data_Valid, PAR_EN, PAR_TYP, output TX_OUT, busy);
endinterface

// File: rtl/uart_tx_parity_gen.sv
// uart_tx_parity_gen: parity bit for the held frame data (even or odd).
module uart_tx_parity_gen
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);
  // Even parity is the XOR of the data; odd parity is its complement.
  assign par_bit = (^data) ^ (par_typ == PAR_ODD);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte-to-serial UART transmitter, one bit per CLK cycle, LSB first.
// Frame: start, DATA_WIDTH data bits, optional parity, stop.
// Optional build macro UART_TX_TWO_STOP_EN: two stop cycles instead of one.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic     CLK,
  input  logic     RST,
  uart_tx_if.slave bus
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  tx_state_t             state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] hold;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_bit;
  logic                  tx_q;
  logic                  busy_q;

  uart_tx_parity_gen #(.DATA_WIDTH(DATA_WIDTH)) u_par (
    .data    (hold),
    .par_typ (par_typ_q),
    .par_bit (par_bit)
  );

  assign bus.TX_OUT = tx_q;
  assign bus.busy   = busy_q;

  // Frame FSM; TX_OUT/busy are registered with the level of the state being entered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hold      <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= IDLE_LVL;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          tx_q   <= IDLE_LVL;
          busy_q <= 1'b0;
          cnt    <= '0;
          if (bus.Data_Valid) begin
            hold      <= bus.P_DATA;
            par_en_q  <= bus.PAR_EN;
            par_typ_q <= bus.PAR_TYP;
            tx_q      <= START_LVL;
            busy_q    <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          cnt   <= '0;
          tx_q  <= hold[0];
          state <= S_DATA;
        end
        S_DATA: begin
          if (cnt == LAST_BIT) begin
            cnt <= '0;
            if (par_en_q) begin
              tx_q  <= par_bit;
              state <= S_PARITY;
            end else begin
              tx_q  <= STOP_LVL;
              state <= S_STOP;
            end
          end else begin
            cnt  <= cnt + 1'b1;
            tx_q <= hold[cnt + 1'b1];
          end
        end
        S_PARITY: begin
          cnt   <= '0;
          tx_q  <= STOP_LVL;
          state <= S_STOP;
        end
        S_STOP: begin
`ifdef UART_TX_TWO_STOP_EN
          // First stop cycle marks cnt, second one closes the frame.
          if (cnt == '0) begin
            cnt  <= CW'(1);
            tx_q <= STOP_LVL;
          end else begin
            cnt    <= '0;
            tx_q   <= IDLE_LVL;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
`else
          cnt    <= '0;
          tx_q   <= IDLE_LVL;
          busy_q <= 1'b0;
          state  <= S_IDLE;
`endif
        end
        default: begin
          cnt    <= '0;
          tx_q   <= IDLE_LVL;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized scoreboard bench for uart_tx with a frame-level reference model.
module tb_uart_tx;
  localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int STOPS = 2;
`else
  localparam int STOPS = 1;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  uart_tx_if #(.DATA_WIDTH(DW)) bus ();
  uart_tx #(.DATA_WIDTH(DW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int checks = 0;
  int passed = 0;

  // Reference model: remaining busy cycles and expected line bits.
  int   remain = 0;
  int   accepts = 0;
  logic exp_bits[$];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
  endtask

  // Acceptance model: a request is taken only when no frame is in flight.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      remain = 0;
      exp_bits.delete();
    end else if (remain > 0) begin
      remain = remain - 1;
    end else if (bus.Data_Valid) begin
      int ones;
      ones = 0;
      exp_bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) begin
        exp_bits.push_back(bus.P_DATA[i]);
        ones += int'(bus.P_DATA[i]);
      end
      if (bus.PAR_EN) exp_bits.push_back(bus.PAR_TYP ? logic'(1 - ones % 2) : logic'(ones % 2));
      for (int i = 0; i < STOPS; i++) exp_bits.push_back(1'b1);
      remain  = 1 + DW + int'(bus.PAR_EN) + STOPS;
      accepts = accepts + 1;
    end
  end

  // Monitor: every cycle compare line and busy with the model.
  always @(negedge CLK) begin
    logic eb;
    eb = (exp_bits.size() > 0) ? exp_bits.pop_front() : 1'b1;
    chk("tx_out", bus.TX_OUT, eb);
    chk("busy", bus.busy, remain > 0);
  end

  task automatic drive(input logic [DW-1:0] d, input logic pe, input logic pt, input logic dv);
    bus.P_DATA = d; bus.PAR_EN = pe; bus.PAR_TYP = pt; bus.Data_Valid = dv;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (remain > 0 && n < 40) begin @(posedge CLK); #1; n++; end
    if (remain > 0) begin checks++; $display("FAIL idle_timeout: remain %0d expected 0", remain); end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
    @(posedge CLK); #1 drive(d, pe, pt, 1'b1);
    @(posedge CLK); #1 bus.Data_Valid = 1'b0;
    wait_idle();
    @(posedge CLK); #1;
  endtask

  initial begin
    int n, a0;
    drive('0, 1'b0, 1'b0, 1'b0);
    // Reset held for 5 cycles; monitor checks idle levels throughout.
    repeat (5) @(posedge CLK);
    #3 RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;

    send(8'hA5, 1'b1, 1'b0);
    send(8'h01, 1'b1, 1'b1);
    send(8'h01, 1'b0, 1'b0);

    // Data_Valid held; data changes mid-frame; second frame after one idle cycle.
    a0 = accepts;
    @(posedge CLK); #1 drive(8'h3C, 1'b1, 1'b0, 1'b1);
    n = 0;
    while (accepts == a0 && n < 10) begin @(posedge CLK); #1; n++; end
    repeat (4) @(posedge CLK);
    #1 bus.P_DATA = 8'hFF;
    n = 0;
    while (accepts < a0 + 2 && n < 40) begin @(posedge CLK); #1; n++; end
    chk("held_dv_two_frames", accepts == a0 + 2, 1'b1);
    bus.Data_Valid = 1'b0;
    wait_idle();

    // Reset during data bit 4 of 8'h55.
    @(posedge CLK); #1 drive(8'h55, 1'b1, 1'b0, 1'b1);
    @(posedge CLK); #1 bus.Data_Valid = 1'b0;
    repeat (5) @(posedge CLK);
    #2 RST = 1'b0;
    #1 chk("rst_tx_async", bus.TX_OUT, 1'b1);
    chk("rst_busy_async", bus.busy, 1'b0);
    #4 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    send(8'hA5, 1'b1, 1'b0);

    // Random traffic including requests while busy and mid-frame input churn.
    for (int c = 0; c < 400; c++) begin
      @(posedge CLK); #1;
      drive(DW'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end
    bus.Data_Valid = 1'b0;
    wait_idle();
    repeat (3) @(posedge CLK);
    #1 chk("queue_drained", exp_bits.size() == 0, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
